// File: rtl/apb_master_bridge.sv
// APB master bridge: single-command valid/ready front end driving one APB
// SETUP/ACCESS transfer at a time, with PREADY timeout and misalignment reject.
module apb_master_bridge #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   // Handshake and status are pure decodes of the state register
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Transfer sequencer with registered APB and response outputs
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_addr[1:0] != 2'b00) begin
                     // Misaligned: answer immediately, never touch the bus
                     rsp_valid <= 1'b1;
                     rsp_error <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end else begin
                     PADDR  <= cmd_addr;
                     PWRITE <= cmd_write;
                     PWDATA <= cmd_write ? cmd_wdata : '0;
                     PSEL   <= 1'b1;
                     state  <= SETUP;
                  end
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // PREADY is checked first so it wins over a coincident timeout
               if (PREADY) begin
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_valid <= 1'b1;
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= RESP;
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_rdata   <= '0;
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  wait_cnt    <= '0;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               // Single-cycle strobe; PSEL already low gives the idle bus cycle
               rsp_valid   <= 1'b0;
               rsp_error   <= 1'b0;
               rsp_timeout <= 1'b0;
               rsp_rdata   <= '0;
               wait_cnt    <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
